// File: rtl/motor_cmd_dispatcher.sv
// motor_cmd_dispatcher
//   Turns the UART byte stream into per-channel motor commands and paces
//   status reports back to the host.
//   A packet is 5 bytes: byte0[3:0] = channel, bytes1..4 = 32-bit word W
//   (LSB first). divider = W[18:4], steps = {1'b0, W[31:19]}.
//   Each channel owns one slot; a slot stays pending until its motor
//   raises activeMode, which takes the command.
// Ports
//   CLK_SE_AR   system clock (24 MHz)
//   rst         asynchronous active-high reset
//   rx_valid    1-cycle strobe, rx_data holds a received byte
//   rx_data     received byte
//   mr_active   activeMode from each motor channel
//   mr_divider  per-channel divider, ch c at [15c+14:15c]
//   mr_steps    per-channel stepsToGo, ch c at [14c+13:14c]
//   pending     slot holds a command the motor has not taken yet
//   tx_start    1-cycle start strobe to the transmitter
//   tx_data     status byte, valid with tx_start
//   tx_busy     transmitter busy
//   err_overrun 1-cycle pulse: packet dropped, slot still pending
//   err_badch   1-cycle pulse: packet dropped, channel out of range
module motor_cmd_dispatcher #(
  parameter int NUM_CH      = 10,
  parameter int TIMEOUT_CYC = 2400,
  parameter int STATUS_GAP  = 8191
) (
  input  logic                 CLK_SE_AR,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic [NUM_CH-1:0]    mr_active,
  output logic [NUM_CH*15-1:0] mr_divider,
  output logic [NUM_CH*14-1:0] mr_steps,
  output logic [NUM_CH-1:0]    pending,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 err_overrun,
  output logic                 err_badch
);

  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(STATUS_GAP + 1);

  typedef enum logic [2:0] {RX_IDLE, RX_B1, RX_B2, RX_B3, RX_B4} rx_state_t;
  typedef enum logic {S_IDLE, S_WAIT} st_state_t;

  rx_state_t rx_state, rx_next;
  st_state_t st_state, st_next;

  logic [3:0]             ch_q;
  logic [7:0]             b1_q, b2_q, b3_q;
  logic [TO_W-1:0]        idle_cnt;
  logic                   timeout;
  logic                   commit;
  logic                   ch_ok;
  logic                   hit_pending;
  logic [NUM_CH-1:0]      load;
  logic [NUM_CH-1:0]      act_prev;
  logic [NUM_CH-1:0]      rise;
  logic [31:0]            word;
  logic [14:0]            new_div;
  logic [13:0]            new_steps;
  logic [NUM_CH-1:0][14:0] div_q;
  logic [NUM_CH-1:0][13:0] steps_q;

  logic                   part;
  logic [GAP_W-1:0]       gap_cnt;
  logic                   issue;
  logic [9:0]             pend_ext;
  logic [4:0]             status_bits;

  assign mr_divider = div_q;
  assign mr_steps   = steps_q;

  // ---- Receive: packet assembly FSM ----
  // Idle-cycle timeout fires on the edge the counter would reach TIMEOUT_CYC.
  always_comb begin
    timeout = (rx_state != RX_IDLE) && !rx_valid &&
              (idle_cnt == TO_W'(TIMEOUT_CYC - 1));
    commit  = rx_valid && (rx_state == RX_B4);
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: if (rx_valid) rx_next = RX_B1;
      RX_B1:   if (rx_valid) rx_next = RX_B2; else if (timeout) rx_next = RX_IDLE;
      RX_B2:   if (rx_valid) rx_next = RX_B3; else if (timeout) rx_next = RX_IDLE;
      RX_B3:   if (rx_valid) rx_next = RX_B4; else if (timeout) rx_next = RX_IDLE;
      RX_B4:   if (rx_valid || timeout) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK_SE_AR or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      idle_cnt <= '0;
    end else begin
      rx_state <= rx_next;
      if (rx_state == RX_IDLE || rx_valid || timeout)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Byte buffers carry data only; their content is meaningless outside a packet.
  always_ff @(posedge CLK_SE_AR) begin
    if (rx_valid) begin
      case (rx_state)
        RX_IDLE: ch_q <= rx_data[3:0];
        RX_B1:   b1_q <= rx_data;
        RX_B2:   b2_q <= rx_data;
        RX_B3:   b3_q <= rx_data;
        default: ;
      endcase
    end
  end

  // ---- Commit decision (cycle of the 5th byte) ----
  // A take edge in the same cycle frees the slot before the commit is judged.
  always_comb begin
    word        = {rx_data, b3_q, b2_q, b1_q};
    new_div     = word[18:4];
    new_steps   = {1'b0, word[31:19]};
    rise        = mr_active & ~act_prev;
    ch_ok       = int'(ch_q) < NUM_CH;
    hit_pending = 1'b0;
    load        = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (commit && ch_ok && int'(ch_q) == c) begin
        if (pending[c] && !rise[c]) hit_pending = 1'b1;
        else                        load[c]     = 1'b1;
      end
    end
  end

  // ---- Slot registers and take detect ----
  always_ff @(posedge CLK_SE_AR or posedge rst) begin
    if (rst) begin
      div_q       <= '0;
      steps_q     <= '0;
      pending     <= '0;
      act_prev    <= '0;
      err_overrun <= 1'b0;
      err_badch   <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (load[c]) begin
          div_q[c]   <= new_div;
          steps_q[c] <= new_steps;
        end else if (rise[c]) begin
          steps_q[c] <= '0;
        end
      end
      pending     <= (pending & ~rise) | load;
      act_prev    <= mr_active;
      err_overrun <= hit_pending;
      err_badch   <= commit && !ch_ok;
    end
  end

  // ---- Status reporter ----
  // Outputs are registered so reset forces tx_start low with no glitch.
  always_comb begin
    pend_ext              = '0;
    pend_ext[NUM_CH-1:0]  = pending;
    status_bits           = part ? pend_ext[9:5] : pend_ext[4:0];
    issue                 = 1'b0;
    st_next               = st_state;
    case (st_state)
      S_IDLE: if ((pending != {NUM_CH{1'b1}}) && !tx_busy) begin
        issue   = 1'b1;
        st_next = S_WAIT;
      end
      S_WAIT: if (gap_cnt <= GAP_W'(1)) st_next = S_IDLE;
      default: st_next = S_IDLE;
    endcase
  end

  // Gap loads STATUS_GAP on a start and returns to idle as it hits 0,
  // so consecutive starts are STATUS_GAP+1 cycles apart.
  always_ff @(posedge CLK_SE_AR or posedge rst) begin
    if (rst) begin
      st_state <= S_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      part     <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      st_state <= st_next;
      tx_start <= issue;
      if (issue) begin
        tx_data <= {part, 2'b00, status_bits};
        part    <= ~part;
        gap_cnt <= GAP_W'(STATUS_GAP);
      end else if (st_state == S_WAIT && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_motor_cmd_dispatcher.sv
// Directed bench for motor_cmd_dispatcher: packet loading, overrun,
// bad channel, mid-packet timeout, same-cycle take/commit, status pacing
// and asynchronous reset.
module tb_motor_cmd_dispatcher;

  localparam int NUM_CH      = 10;
  localparam int TIMEOUT_CYC = 2400;
  localparam int STATUS_GAP  = 8191;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic [NUM_CH-1:0]    mr_active;
  logic [NUM_CH*15-1:0] mr_divider;
  logic [NUM_CH*14-1:0] mr_steps;
  logic [NUM_CH-1:0]    pending;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 err_overrun;
  logic                 err_badch;

  motor_cmd_dispatcher #(
    .NUM_CH(NUM_CH), .TIMEOUT_CYC(TIMEOUT_CYC), .STATUS_GAP(STATUS_GAP)
  ) dut (
    .CLK_SE_AR(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .mr_active(mr_active), .mr_divider(mr_divider), .mr_steps(mr_steps),
    .pending(pending), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .err_overrun(err_overrun), .err_badch(err_badch)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_ovr = 0;
  int n_bad = 0;
  int n_tx  = 0;
  int tx_t [4];
  logic [7:0] tx_b [4];

  always @(posedge clk) cyc <= cyc + 1;

  // Event counters sampled on the falling edge.
  always @(negedge clk) begin
    if (err_overrun) n_ovr++;
    if (err_badch)   n_bad++;
    if (tx_start) begin
      if (n_tx < 4) begin
        tx_t[n_tx] = cyc;
        tx_b[n_tx] = tx_data;
      end
      n_tx++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] div_of(input int c);
    return 32'(mr_divider[15*c +: 15]);
  endfunction

  function automatic logic [31:0] steps_of(input int c);
    return 32'(mr_steps[14*c +: 14]);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit raise2);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    if (raise2) mr_active[2] = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] ch, input logic [31:0] w, input bit raise2);
    send_byte(ch, 1'b0);
    send_byte(w[7:0], 1'b0);
    send_byte(w[15:8], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[31:24], raise2);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    mr_active = '0;
    tx_busy   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_pending",  32'(pending), 32'h0);
    check_val("rst_divider",  32'(|mr_divider), 32'h0);
    check_val("rst_txstart",  32'(tx_start), 32'h0);
    check_val("rst_txdata",   32'(tx_data), 32'h0);
    check_val("rst_errs",     32'({err_overrun, err_badch}), 32'h0);
    rst = 1'b0;

    // T1: W = 0x34120000 -> divider W[18:4] = 0x2000, steps W[31:19] = 0x682
    send_pkt(8'h03, 32'h3412_0000, 1'b0);
    check_val("t1_div3",    div_of(3), 32'h2000);
    check_val("t1_steps3",  steps_of(3), 32'h0682);
    check_val("t1_pending", 32'(pending), 32'h008);
    check_val("t1_errs",    32'(n_ovr + n_bad), 32'h0);

    // T2: ch3 still pending -> overrun, slot unchanged
    send_pkt(8'h03, 32'hFFFF_FFFF, 1'b0);
    check_val("t2_ovr",     32'(n_ovr), 32'h1);
    check_val("t2_div3",    div_of(3), 32'h2000);
    check_val("t2_steps3",  steps_of(3), 32'h0682);
    check_val("t2_pending", 32'(pending), 32'h008);

    // T3: channel 12 out of range
    send_pkt(8'h0C, 32'h4433_2211, 1'b0);
    check_val("t3_bad",     32'(n_bad), 32'h1);
    check_val("t3_pending", 32'(pending), 32'h008);
    check_val("t3_div2",    div_of(2), 32'h0);
    check_val("t3_div3",    div_of(3), 32'h2000);

    // T4: partial packet to ch5 abandoned by timeout; W = 0x00081230
    send_byte(8'h05, 1'b0);
    send_byte(8'hAA, 1'b0);
    repeat (TIMEOUT_CYC + 1) @(posedge clk);
    #1;
    send_pkt(8'h01, 32'h0008_1230, 1'b0);
    check_val("t4_div1",    div_of(1), 32'h0123);
    check_val("t4_steps1",  steps_of(1), 32'h0001);
    check_val("t4_pending", 32'(pending), 32'h00A);
    check_val("t4_errs",    32'(n_ovr + n_bad), 32'h2);

    // T5: ch2 load, then take edge coincident with the next commit
    send_pkt(8'h02, 32'h0100_0000, 1'b0);
    check_val("t5_steps2a", steps_of(2), 32'h0020);
    check_val("t5_pend_a",  32'(pending), 32'h00E);
    send_pkt(8'h02, 32'h00A8_0010, 1'b1);
    check_val("t5_div2",    div_of(2), 32'h0001);
    check_val("t5_steps2",  steps_of(2), 32'h0015);
    check_val("t5_pend_b",  32'(pending), 32'h00E);
    check_val("t5_ovr",     32'(n_ovr), 32'h1);

    // Fill the remaining slots: all pending -> reporter stays silent
    send_pkt(8'h00, 32'h0, 1'b0);
    for (int c = 4; c < NUM_CH; c++) send_pkt(8'(c), 32'h0, 1'b0);
    check_val("full_pending", 32'(pending), 32'h3FF);
    tx_busy = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check_val("full_no_tx", 32'(n_tx), 32'h0);

    // Take on every channel: pending clears, steps zeroed, divider held
    mr_active = '0;
    repeat (2) @(posedge clk);
    #1;
    mr_active = '1;
    repeat (2) @(posedge clk);
    #1;
    check_val("take_pending", 32'(pending), 32'h0);
    check_val("take_steps2",  steps_of(2), 32'h0);
    check_val("take_div2",    div_of(2), 32'h0001);
    check_val("take_div3",    div_of(3), 32'h2000);

    // T6: status bytes 0x00 then 0x80, STATUS_GAP+1 cycles apart
    for (int i = 0; i < 10000 && n_tx < 2; i++) @(posedge clk);
    #1;
    check_val("t6_two_tx",  32'(n_tx >= 2), 32'h1);
    check_val("t6_byte0",   32'(tx_b[0]), 32'h00);
    check_val("t6_byte1",   32'(tx_b[1]), 32'h80);
    check_val("t6_spacing", 32'(tx_t[1] - tx_t[0]), 32'(STATUS_GAP + 1));
    repeat (100) @(posedge clk);
    #1;
    check_val("t6_gap_quiet", 32'(n_tx), 32'h2);
    check_val("t6_txdata_held", 32'(tx_data), 32'h80);

    // Reset mid-gap: outputs clear without waiting for a clock edge
    rst = 1'b1;
    #1;
    check_val("rst2_txdata",  32'(tx_data), 32'h0);
    check_val("rst2_txstart", 32'(tx_start), 32'h0);
    check_val("rst2_divider", 32'(|mr_divider), 32'h0);
    check_val("rst2_pending", 32'(pending), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst2_no_tx", 32'(n_tx), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
